fpu_cmp_seq_ctl: RTL

Multi-cycle sequencer that compares two WIDTH-bit unsigned operands 2 bits per cycle, MSB slice first, using a 2-bit in2-greater-than-in1 / not-equal slice evaluation. It serves area-constrained FPU compare paths such as exponent/mantissa magnitude checks, where a full-width comparator is not warranted. It provides a req/rdy operand handshake and a vld/ack result handshake, optional early termination, and a kill input.

---
 rtl/fpu_cmp_seq_ctl.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/fpu_cmp_seq_ctl.sv
// Sequential magnitude/inequality compare of two WIDTH-bit operands, 2 bits per cycle, MSB slice first.
// Latency: result from T+2+j on the first differing slice j (EARLY_OUT=1), else T+1+WIDTH/2.
// Backpressure: cmp_rdy only in IDLE; the result is held in DONE until res_ack; cmp_kill aborts.
//
// Ports:
//   rclk, grst_l        clock, synchronous active-low reset
//   cmp_req / cmp_rdy   operand handshake; cmp_din1/cmp_din2 are sampled on accept
//   cmp_kill            abort the current operation (also blocks an accept in IDLE)
//   cmp_busy            compare in progress
//   res_vld / res_ack   result handshake; res_gt = din2 > din1, res_neq = din2 != din1
module fpu_cmp_seq_ctl #(
    parameter int WIDTH     = 64,
    parameter bit EARLY_OUT = 1'b1
) (
    input  logic             rclk,
    input  logic             grst_l,
    input  logic             cmp_req,
    output logic             cmp_rdy,
    input  logic [WIDTH-1:0] cmp_din1,
    input  logic [WIDTH-1:0] cmp_din2,
    input  logic             cmp_kill,
    output logic             cmp_busy,
    output logic             res_vld,
    input  logic             res_ack,
    output logic             res_gt,
    output logic             res_neq
);

    localparam int NS = WIDTH / 2;
    localparam int IW = (NS > 1) ? $clog2(NS) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CMP  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [IW-1:0]    idx_q;
    logic [WIDTH-1:0] op1_q;
    logic [WIDTH-1:0] op2_q;
    logic             gt_q;
    logic             neq_q;

    logic [1:0]       sa;
    logic [1:0]       sb;
    logic             s_neq;
    logic             s_gt;
    logic             accept;
    logic             last_slice;

    // Operands are shifted left by one slice per CMP cycle, so the slice
    // under evaluation is always the top two bits; idx_q only counts slices.
    assign sa         = op1_q[WIDTH-1 -: 2];
    assign sb         = op2_q[WIDTH-1 -: 2];
    assign s_neq      = (sa != sb);
    assign s_gt       = (~sa[1] & sb[1]) | ((sa[1] == sb[1]) & ~sa[0] & sb[0]);
    assign accept     = (state_q == S_IDLE) && cmp_req && !cmp_kill;
    assign last_slice = (idx_q == '0);

    assign cmp_rdy  = (state_q == S_IDLE);
    assign cmp_busy = (state_q == S_CMP);
    assign res_vld  = (state_q == S_DONE);
    assign res_gt   = gt_q;
    assign res_neq  = neq_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_CMP;
                end
            end
            S_CMP: begin
                if (cmp_kill) begin
                    state_d = S_IDLE;
                end else if ((EARLY_OUT && s_neq) || last_slice) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                // kill and ack both return to IDLE; kill additionally clears the flags
                if (cmp_kill || res_ack) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge rclk) begin
        if (!grst_l) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            op1_q   <= '0;
            op2_q   <= '0;
            gt_q    <= 1'b0;
            neq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        op1_q <= cmp_din1;
                        op2_q <= cmp_din2;
                        idx_q <= IW'(NS - 1);
                        gt_q  <= 1'b0;
                        neq_q <= 1'b0;
                    end
                end
                S_CMP: begin
                    if (cmp_kill) begin
                        gt_q  <= 1'b0;
                        neq_q <= 1'b0;
                    end else begin
                        op1_q <= op1_q << 2;
                        op2_q <= op2_q << 2;
                        if (!last_slice) begin
                            idx_q <= idx_q - IW'(1);
                        end
                        // only the most significant differing slice decides the result
                        if (s_neq && !neq_q) begin
                            neq_q <= 1'b1;
                            gt_q  <= s_gt;
                        end
                    end
                end
                S_DONE: begin
                    if (cmp_kill) begin
                        gt_q  <= 1'b0;
                        neq_q <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
